// File: rtl/svn_seg_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | svn_seg_pkg : shared types and seven-segment ROM for the scan control |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package svn_seg_pkg;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } seg_state_e;

  // Active-high a-g in [6:0] (a = bit 0); bit 7 reserved for dp, always 0 here.
  localparam logic [15:0][7:0] SEG_ROM = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

endpackage
`default_nettype wire

// File: rtl/svn_seg_dec.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | svn_seg_dec : hex nibble to segment pattern with blanking + polarity  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module svn_seg_dec #(
  parameter bit LED_POLARITY = 1'b0
) (
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);
  import svn_seg_pkg::*;

  logic [7:0] w_rom;
  logic [7:0] w_raw;

  assign w_rom = SEG_ROM[nib_i];
  // A blanked digit still carries its decimal point.
  assign w_raw = {dp_i, (blank_i ? 7'h00 : w_rom[6:0])};
  assign seg_o = w_raw ^ {8{~LED_POLARITY}};

endmodule
`default_nettype wire

// File: rtl/svn_seg_scan_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | svn_seg_scan_ctrl : 3-digit multiplexed seven-segment scan controller |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module svn_seg_scan_ctrl #(
  parameter byte CLK_IN_MHZ   = 125,
  parameter bit  LED_POLARITY = 1'b0,
  parameter bit  SEL_POLARITY = 1'b1,
  parameter int  SCAN_HZ      = 1000,
  parameter int  BLANK_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [11:0] value_i,
  input  logic [2:0]  dp_i,
  input  logic        lzb_en_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [7:0]  seg_display_o,
  output logic [2:0]  seg_sel_o
);
  import svn_seg_pkg::*;

`ifdef SIM
  localparam int DWELL = 4;
`else
  localparam int DWELL = (int'(CLK_IN_MHZ) * 1000000) / SCAN_HZ - BLANK_CYCLES;
`endif
  localparam int         DW_W    = $clog2(DWELL + 1);
  localparam logic [7:0] SEG_OFF = LED_POLARITY ? 8'h00 : 8'hFF;
  localparam logic [2:0] SEL_OFF = SEL_POLARITY ? 3'b000 : 3'b111;

  if (DWELL < 1) begin : g_bad_dwell
    $error("svn_seg_scan_ctrl: DWELL must be at least 1");
  end
  if (BLANK_CYCLES < 1 || BLANK_CYCLES > 255) begin : g_bad_blank
    $error("svn_seg_scan_ctrl: BLANK_CYCLES must be 1..255");
  end

  seg_state_e       state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       blank_cnt_q, blank_cnt_d;
  logic [DW_W-1:0]  dwell_cnt_q, dwell_cnt_d;
  logic             pending_q, pending_d;
  logic [11:0]      shadow_val_q, shadow_val_d, act_val_q, act_val_d;
  logic [2:0]       shadow_dp_q, shadow_dp_d, act_dp_q, act_dp_d;
  logic             shadow_lzb_q, shadow_lzb_d, act_lzb_q, act_lzb_d;
  logic [7:0]       seg_display_q, seg_display_d;
  logic [2:0]       seg_sel_q, seg_sel_d;

  logic             w_accept, w_boundary;
  logic [3:0]       w_nib;
  logic             w_dp, w_blank;
  logic [7:0]       w_dec_seg;

  assign w_accept   = valid_i & ~pending_q;
  assign w_boundary = (state_q == ST_BLANK) && (idx_q == 2'd0) && (blank_cnt_q == 8'd0);

  // Decode from the next active value so a transfer is visible even with a 1-cycle blank.
  always_comb begin
    w_nib   = act_val_d[3:0];
    w_dp    = act_dp_d[0];
    w_blank = 1'b0;
    case (idx_q)
      2'd1: begin
        w_nib   = act_val_d[7:4];
        w_dp    = act_dp_d[1];
        w_blank = act_lzb_d && (act_val_d[11:8] == 4'd0) && (act_val_d[7:4] == 4'd0);
      end
      2'd2: begin
        w_nib   = act_val_d[11:8];
        w_dp    = act_dp_d[2];
        w_blank = act_lzb_d && (act_val_d[11:8] == 4'd0);
      end
      default: ;
    endcase
  end

  svn_seg_dec #(.LED_POLARITY(LED_POLARITY)) u_dec (
    .nib_i   (w_nib),
    .dp_i    (w_dp),
    .blank_i (w_blank),
    .seg_o   (w_dec_seg)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    blank_cnt_d   = blank_cnt_q;
    dwell_cnt_d   = dwell_cnt_q;
    pending_d     = pending_q;
    shadow_val_d  = shadow_val_q;
    shadow_dp_d   = shadow_dp_q;
    shadow_lzb_d  = shadow_lzb_q;
    act_val_d     = act_val_q;
    act_dp_d      = act_dp_q;
    act_lzb_d     = act_lzb_q;
    seg_display_d = seg_display_q;
    seg_sel_d     = seg_sel_q;

    if (w_accept) begin
      shadow_val_d = value_i;
      shadow_dp_d  = dp_i;
      shadow_lzb_d = lzb_en_i;
      pending_d    = 1'b1;
    end
    if (w_boundary && pending_q) begin
      act_val_d = shadow_val_q;
      act_dp_d  = shadow_dp_q;
      act_lzb_d = shadow_lzb_q;
      pending_d = 1'b0;
    end

    case (state_q)
      ST_BLANK: begin
        if (blank_cnt_q == 8'(BLANK_CYCLES - 1)) begin
          state_d       = ST_DRIVE;
          blank_cnt_d   = 8'd0;
          seg_display_d = w_dec_seg;
          seg_sel_d     = (3'b001 << idx_q) ^ SEL_OFF;
        end else begin
          blank_cnt_d = blank_cnt_q + 8'd1;
        end
      end
      default: begin
        if (dwell_cnt_q == DW_W'(DWELL - 1)) begin
          state_d       = ST_BLANK;
          dwell_cnt_d   = '0;
          idx_d         = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
          seg_display_d = SEG_OFF;
          seg_sel_d     = SEL_OFF;
        end else begin
          dwell_cnt_d = dwell_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_BLANK;
      idx_q         <= 2'd0;
      blank_cnt_q   <= 8'd0;
      dwell_cnt_q   <= '0;
      pending_q     <= 1'b0;
      shadow_val_q  <= 12'd0;
      shadow_dp_q   <= 3'd0;
      shadow_lzb_q  <= 1'b0;
      act_val_q     <= 12'd0;
      act_dp_q      <= 3'd0;
      act_lzb_q     <= 1'b0;
      seg_display_q <= SEG_OFF;
      seg_sel_q     <= SEL_OFF;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      blank_cnt_q   <= blank_cnt_d;
      dwell_cnt_q   <= dwell_cnt_d;
      pending_q     <= pending_d;
      shadow_val_q  <= shadow_val_d;
      shadow_dp_q   <= shadow_dp_d;
      shadow_lzb_q  <= shadow_lzb_d;
      act_val_q     <= act_val_d;
      act_dp_q      <= act_dp_d;
      act_lzb_q     <= act_lzb_d;
      seg_display_q <= seg_display_d;
      seg_sel_q     <= seg_sel_d;
    end
  end

  assign ready_o       = ~pending_q;
  assign seg_display_o = seg_display_q;
  assign seg_sel_o     = seg_sel_q;

endmodule
`default_nettype wire
